reg_writeback: RTL and testbench

//  Writeback unit that drives the register-file write port (Caddr/C/Load).

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/reg_writeback.sv | 102 ++++++++++
 tb/tb_reg_writeback.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants, entry payload and register decode for the writeback unit.
package wb_pkg;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NREG  = 1 << AW;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] REG_ZERO = 4'd0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    function automatic logic [NREG-1:0] dec(input logic [AW-1:0] a);
        return NREG'(1) << a;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer: two enqueues (in0 older than in1) and one dequeue per clock.
// Entries are presented oldest-first in ord[] with matching ord_vld bits.
module wb_fifo
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in0_en,
    input  entry_t           in0,
    input  logic             in1_en,
    input  entry_t           in1,
    output logic             pop,
    output logic [CW-1:0]    count,
    output entry_t           ord [DEPTH],
    output logic [DEPTH-1:0] ord_vld
);
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    entry_t        mem [DEPTH];

    // A flush suppresses the pop so the cleared queue cannot leak its head.
    assign pop = (count != '0) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= head + PW'(1);
            if (in1_en)
                tail <= tail + PW'(2);
            else if (in0_en)
                tail <= tail + PW'(1);
            count <= count + CW'(in0_en) + CW'(in1_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (in0_en)
                mem[tail] <= in0;
            if (in1_en)
                mem[tail + PW'(1)] <= in1;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ord[k]     = mem[head + PW'(k)];
            ord_vld[k] = CW'(k) < count;
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback: merges ALU/load results into an in-order queue, retires one per clock.
// Optional WB_BYPASS_EN adds a combinational forwarding lookup (byp_addr/byp_hit/byp_data).
module reg_writeback
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_addr,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    input  logic            flush,
    output logic            wr_load,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [NREG-1:0] busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]   byp_addr,
    output logic            byp_hit,
    output logic [DW-1:0]   byp_data
`endif
);
    logic             pop;
    logic [CW-1:0]    count;
    entry_t           ord [DEPTH];
    logic [DEPTH-1:0] ord_vld;
    logic             mem_enq;
    logic             alu_enq;
    entry_t           mem_e;
    entry_t           alu_e;

    // Readiness ignores a same-cycle dequeue; the mem slot is reserved first.
    assign mem_ready = !flush && (count < CW'(DEPTH));
    assign alu_ready = !flush && ((count + CW'(mem_valid)) < CW'(DEPTH));

    assign mem_enq = mem_valid && mem_ready && (mem_addr != REG_ZERO);
    assign alu_enq = alu_valid && alu_ready && (alu_addr != REG_ZERO);
    assign mem_e   = '{addr: mem_addr, data: mem_data};
    assign alu_e   = '{addr: alu_addr, data: alu_data};

    wb_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in0_en  (mem_enq || alu_enq),
        .in0     (mem_enq ? mem_e : alu_e),
        .in1_en  (mem_enq && alu_enq),
        .in1     (alu_e),
        .pop     (pop),
        .count   (count),
        .ord     (ord),
        .ord_vld (ord_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_load <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_load <= pop;
            if (pop) begin
                wr_addr <= ord[0].addr;
                wr_data <= ord[0].data;
            end
        end
    end

    always_comb begin
        busy = wr_load ? dec(wr_addr) : '0;
        for (int k = 0; k < DEPTH; k++)
            if (ord_vld[k])
                busy = busy | dec(ord[k].addr);
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match is the freshest value.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (wr_load && (wr_addr == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = wr_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (ord_vld[k] && (ord[k].addr == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = ord[k].data;
            end
        end
        if (byp_addr == REG_ZERO) begin
            byp_hit  = 1'b0;
            byp_data = '0;
        end
    end
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: drivers queue expected retirements, a monitor checks wr_*.
module tb_reg_writeback;
    import wb_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;
    logic            flush;
    logic            wr_load;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] busy;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   byp_addr;
    logic            byp_hit;
    logic [DW-1:0]   byp_data;
`endif

    int checks   = 0;
    int failures = 0;

    entry_t exp_q[$];
    entry_t mem_q[$];
    entry_t alu_q[$];
    logic   rd_log[$];

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .flush     (flush),
        .wr_load   (wr_load),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr  (byp_addr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every retirement must match the oldest expected write.
    always @(negedge clk) begin
        entry_t e;
        if (!rst && wr_load) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got r%0d=%h expected none", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("retire", 32'({wr_addr, wr_data}), 32'({e.addr, e.data}));
            end
        end
    end

    // Offer queued mem/alu items each cycle; accepted non-zero writes go to the scoreboard, mem first.
    task automatic stream(input int bound);
        logic m_acc;
        logic a_acc;
        int   cyc;
        cyc = 0;
        while ((mem_q.size() != 0 || alu_q.size() != 0) && cyc < bound) begin
            @(negedge clk);
            mem_valid = (mem_q.size() != 0);
            alu_valid = (alu_q.size() != 0);
            if (mem_valid) begin
                mem_addr = mem_q[0].addr;
                mem_data = mem_q[0].data;
            end
            if (alu_valid) begin
                alu_addr = alu_q[0].addr;
                alu_data = alu_q[0].data;
            end
            #1;
            m_acc = mem_valid && mem_ready;
            a_acc = alu_valid && alu_ready;
            if (alu_valid)
                rd_log.push_back(alu_ready);
            @(posedge clk);
            if (m_acc) begin
                if (mem_q[0].addr != REG_ZERO)
                    exp_q.push_back(mem_q[0]);
                void'(mem_q.pop_front());
            end
            if (a_acc) begin
                if (alu_q[0].addr != REG_ZERO)
                    exp_q.push_back(alu_q[0]);
                void'(alu_q.pop_front());
            end
            cyc++;
        end
        @(negedge clk);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        if (mem_q.size() != 0 || alu_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout: got %0d items pending expected 0", mem_q.size() + alu_q.size());
            mem_q.delete();
            alu_q.delete();
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0)
                break;
            @(negedge clk);
        end
        @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic exp_rd[7];
        exp_rd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rst = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
`ifdef WB_BYPASS_EN
        byp_addr = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_wr_load", 32'(wr_load), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);

        // Reset mid-traffic: two queued writes are lost.
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 16'h0777;
        alu_valid = 1'b1; alu_addr = 4'd8; alu_data = 16'h0888;
        @(negedge clk);
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk("mid_busy_before", 32'(busy), 32'h0180);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_load", 32'(wr_load), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("mid_rst_busy_after", 32'(busy), 32'd0);

        // Single write r3=0004: retires two edges after accept.
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h0004;
        #1;
        chk("single_alu_ready", 32'(alu_ready), 32'd1);
        exp_q.push_back('{addr: 4'd3, data: 16'h0004});
        @(negedge clk);
        alu_valid = 1'b0;
        chk("single_busy_queued", 32'(busy), 32'h0008);
        chk("single_wr_load_early", 32'(wr_load), 32'd0);
        @(negedge clk);
        chk("single_wr_load", 32'(wr_load), 32'd1);
        chk("single_wr_addr", 32'(wr_addr), 32'd3);
        chk("single_wr_data", 32'(wr_data), 32'h0004);
        chk("single_busy_retire", 32'(busy), 32'h0008);
        @(negedge clk);
        chk("single_wr_load_done", 32'(wr_load), 32'd0);
        chk("single_wr_addr_hold", 32'(wr_addr), 32'd3);
        chk("single_busy_clear", 32'(busy), 32'd0);

        // Dual accept to r5: mem value AA retires before alu value 55.
        mem_q.push_back('{addr: 4'd5, data: 16'h00AA});
        alu_q.push_back('{addr: 4'd5, data: 16'h0055});
        stream(20);
        drain("dual_drain");
        chk("dual_busy5", 32'(busy[5]), 32'd0);

        // Back-pressure: mem and alu offered together; alu stalls at count=3 while mem_valid.
        rd_log.delete();
        for (int i = 1; i <= 4; i++)
            mem_q.push_back('{addr: AW'(i), data: DW'(16'h1000 + i)});
        for (int i = 9; i <= 13; i++)
            alu_q.push_back('{addr: AW'(i), data: DW'(16'h0A00 + i)});
        stream(40);
        chk("full_rd_len", 32'(rd_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < rd_log.size(); i++)
            chk($sformatf("full_alu_ready_%0d", i), 32'(rd_log[i]), 32'(exp_rd[i]));
        drain("full_drain");
        chk("full_busy", 32'(busy), 32'd0);

        // Register 0: handshake completes but nothing is written.
        rd_log.delete();
        alu_q.push_back('{addr: 4'd0, data: 16'hFFFF});
        stream(10);
        chk("zero_handshake", 32'(rd_log.size() == 1 && rd_log[0] == 1'b1), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_wr_load", 32'(wr_load), 32'd0);
            @(negedge clk);
        end

        // Flush: r1 reaches wr_*, r2/r3 are dropped.
        mem_valid = 1'b1; mem_addr = 4'd1; mem_data = 16'h0111;
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h0222;
        exp_q.push_back('{addr: 4'd1, data: 16'h0111});
        @(negedge clk);
        mem_valid = 1'b0;
        alu_addr = 4'd3; alu_data = 16'h0333;
        #1;
        chk("flush_alu_ready_pre", 32'(alu_ready), 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        chk("flush_busy_pre", 32'(busy), 32'h000E);
`ifdef WB_BYPASS_EN
        byp_addr = 4'd2;
        #1;
        chk("byp_hit_r2", 32'(byp_hit), 32'd1);
        chk("byp_data_r2", 32'(byp_data), 32'h0222);
        byp_addr = 4'd1;
        #1;
        chk("byp_data_r1", 32'(byp_data), 32'h0111);
        byp_addr = 4'd0;
        #1;
        chk("byp_hit_r0", 32'(byp_hit), 32'd0);
`endif
        flush = 1'b1;
        #1;
        chk("flush_mem_ready", 32'(mem_ready), 32'd0);
        chk("flush_alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_post", 32'(busy), 32'd0);
        chk("flush_wr_load_post", 32'(wr_load), 32'd0);
        #1;
        chk("flush_ready_post", 32'(alu_ready && mem_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("flush_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
